// File: rtl/filter_bank_buffer_if.sv
// filter_bank_buffer_if: load, swap, read and scan signals of the filter coefficient store
interface filter_bank_buffer_if #(
  parameter int DATA_W = 8,
  parameter int K = 4,
  parameter int IDX_W = $clog2(K)
);
  logic ld_valid;
  logic ld_ready;
  logic [IDX_W-1:0] ld_row;
  logic [K*DATA_W-1:0] ld_data;
  logic shadow_full;
  logic swap_req;
  logic act_valid;
  logic rd_en;
  logic [IDX_W-1:0] rd_row;
  logic [IDX_W-1:0] rd_col;
  logic scan_start;
  logic scan_busy;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_last;
  modport master (
    output ld_valid, ld_row, ld_data, swap_req, rd_en, rd_row, rd_col, scan_start,
    input ld_ready, shadow_full, act_valid, scan_busy, out_data, out_valid, out_last
  );
  modport slave (
    input ld_valid, ld_row, ld_data, swap_req, rd_en, rd_row, rd_col, scan_start,
    output ld_ready, shadow_full, act_valid, scan_busy, out_data, out_valid, out_last
  );
endinterface

// File: rtl/filter_bank_buffer.sv
// filter_bank_buffer: double-banked KxK coefficient store with shadow loading, random read and raster scan
module filter_bank_buffer #(
  parameter int DATA_W = 8,
  parameter int K = 4,
  parameter int IDX_W = $clog2(K)
) (
  input logic clk,
  input logic rst_n,
  filter_bank_buffer_if.slave bus
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem_q [2][K][K];
  logic [K-1:0] mask_q, mask_d;
  logic sel_q, sel_d, full_q, full_d, act_q, act_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d, a_row, a_col;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic busy, last_el, scan_go, rd_go, swap_go, ld_go;
  assign busy = state_q == SCAN;
  assign last_el = row_q == LAST && col_q == LAST;
  assign scan_go = state_q == IDLE && bus.scan_start && act_q;
  assign rd_go = bus.rd_en && !busy && !scan_go;
  assign swap_go = full_q && bus.swap_req && !busy;
  assign ld_go = bus.ld_valid && !full_q && int'(bus.ld_row) < K;
  always_comb begin
    state_d = scan_go ? SCAN : (busy && last_el) ? IDLE : state_q;
    row_d = scan_go ? '0 : (busy && col_q == LAST) ? row_q + 1'b1 : row_q;
    col_d = scan_go ? IDX_W'(1) : busy ? (col_q == LAST ? '0 : col_q + 1'b1) : col_q;
  end
  // Scan owns the read port while busy; a starting scan reads element (0,0)
  always_comb begin
    a_row = busy ? row_q : scan_go ? '0 : bus.rd_row;
    a_col = busy ? col_q : scan_go ? '0 : bus.rd_col;
    out_valid_d = busy || scan_go || rd_go;
    out_last_d = busy && last_el;
    out_data_d = !out_valid_d ? out_data_q :
                 (int'(a_row) < K && int'(a_col) < K) ? mem_q[sel_q][a_row][a_col] : '0;
  end
  always_comb begin
    mask_d = mask_q;
    if (ld_go) mask_d[bus.ld_row] = 1'b1;
    if (swap_go) mask_d = '0;
  end
  assign full_d = &mask_d;
  assign sel_d = sel_q ^ swap_go;
  assign act_d = act_q | swap_go;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q <= '0;
      sel_q <= 1'b0;
      full_q <= 1'b0;
      act_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) mem_q[b][r][c] <= '0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      sel_q <= sel_d;
      full_q <= full_d;
      act_q <= act_d;
      row_q <= row_d;
      col_q <= col_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      if (ld_go)
        for (int c = 0; c < K; c++)
          mem_q[~sel_q][bus.ld_row][c] <= bus.ld_data[(K-1-c)*DATA_W +: DATA_W];
    end
  end
  assign bus.ld_ready = !full_q;
  assign bus.shadow_full = full_q;
  assign bus.act_valid = act_q;
  assign bus.scan_busy = busy;
  assign bus.out_data = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last = out_last_q;
endmodule

// File: tb/tb_filter_bank_buffer.sv
// tb_filter_bank_buffer: directed stimulus with a queue-based reference model and literal spot checks
module tb_filter_bank_buffer;
  localparam int DW = 8;
  localparam int K = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  filter_bank_buffer_if #(.DATA_W(DW), .K(K)) bus();
  filter_bank_buffer #(.DATA_W(DW), .K(K)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: active/shadow filters as plain arrays, a scan as a queue of pending elements
  logic [DW-1:0] m_act [K][K];
  logic [DW-1:0] m_shd [K][K];
  logic [K-1:0] m_mask;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_data, tmp;
  bit m_full, m_actv, exp_valid, exp_last;
  always @(posedge clk or negedge rst_n) begin
    bit busy0, go;
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) begin
          m_act[r][c] = '0;
          m_shd[r][c] = '0;
        end
      q.delete();
      m_mask = '0;
      m_full = 0;
      m_actv = 0;
      exp_data = '0;
      exp_valid = 0;
      exp_last = 0;
    end else begin
      busy0 = q.size() != 0;
      go = 0;
      exp_valid = 1;
      exp_last = 0;
      if (busy0) begin
        exp_data = q.pop_front();
        exp_last = q.size() == 0;
      end else if (bus.scan_start && m_actv) begin
        exp_data = m_act[0][0];
        go = 1;
      end else if (bus.rd_en)
        exp_data = (int'(bus.rd_row) < K && int'(bus.rd_col) < K) ? m_act[bus.rd_row][bus.rd_col] : '0;
      else
        exp_valid = 0;
      if (m_full && bus.swap_req && !busy0) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) begin
            tmp = m_act[r][c];
            m_act[r][c] = m_shd[r][c];
            m_shd[r][c] = tmp;
          end
        m_mask = '0;
        m_actv = 1;
      end
      if (bus.ld_valid && !m_full && int'(bus.ld_row) < K) begin
        for (int c = 0; c < K; c++) m_shd[bus.ld_row][c] = DW'(bus.ld_data >> ((K - 1 - c) * DW));
        m_mask[bus.ld_row] = 1'b1;
      end
      m_full = &m_mask;
      if (go)
        for (int i = 1; i < K * K; i++) q.push_back(m_act[i / K][i % K]);
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      checks++;
      if ({bus.out_valid, bus.out_last, bus.scan_busy, bus.ld_ready, bus.shadow_full, bus.act_valid, bus.out_data}
          !== {exp_valid, exp_last, q.size() != 0, !m_full, m_full, m_actv, exp_data}) begin
        errors++;
        $display("FAIL model v/l/busy/rdy/full/act/data got %b %b %b %b %b %b %h expected %b %b %b %b %b %b %h at %0t",
                 bus.out_valid, bus.out_last, bus.scan_busy, bus.ld_ready, bus.shadow_full, bus.act_valid, bus.out_data,
                 exp_valid, exp_last, q.size() != 0, !m_full, m_full, m_actv, exp_data, $time);
      end
    end
  end

  task automatic idle();
    bus.ld_valid = 0;
    bus.swap_req = 0;
    bus.rd_en = 0;
    bus.scan_start = 0;
  endtask
  task automatic sample();
    @(posedge clk);
    #2;
  endtask
  task automatic load(input int r, input logic [31:0] d);
    @(negedge clk);
    idle();
    bus.ld_valid = 1;
    bus.ld_row = 2'(r);
    bus.ld_data = d;
  endtask
  task automatic rd(input int r, input int c);
    @(negedge clk);
    idle();
    bus.rd_en = 1;
    bus.rd_row = 2'(r);
    bus.rd_col = 2'(c);
  endtask

  initial begin
    idle();
    bus.ld_row = '0;
    bus.ld_data = '0;
    bus.rd_row = '0;
    bus.rd_col = '0;
    #8;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_ld_ready", bus.ld_ready, 1);
    chk("rst_act_valid", bus.act_valid, 0);
    chk("rst_busy", bus.scan_busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int r = 0; r < K; r++) load(r, 32'h00010203 + r * 32'h10101010);
    sample();
    chk("full_after_4", bus.shadow_full, 1);
    chk("ready_after_4", bus.ld_ready, 0);
    chk("act_before_swap", bus.act_valid, 0);
    @(negedge clk);
    idle();
    bus.swap_req = 1;
    sample();
    chk("act_after_swap", bus.act_valid, 1);
    chk("ready_after_swap", bus.ld_ready, 1);
    rd(2, 1);
    sample();
    chk("rd_2_1", bus.out_data, 32'h21);
    rd(3, 3);
    sample();
    chk("rd_3_3", bus.out_data, 32'h33);
    // Two gapless scans; a start mid-scan is ignored, one in the last cycle chains
    @(negedge clk);
    idle();
    bus.scan_start = 1;
    for (int i = 0; i < 32; i++) begin
      sample();
      chk("scan_data", bus.out_data, ((i % 16) / 4) * 16 + i % 4);
      chk("scan_last", bus.out_last, (i % 16) == 15);
      @(negedge clk);
      bus.scan_start = (i == 4 || i == 15);
    end
    sample();
    chk("scan_end_valid", bus.out_valid, 0);
    // Load a new filter during a scan and hold swap_req; swap must wait for the scan to end
    @(negedge clk);
    idle();
    bus.scan_start = 1;
    for (int i = 0; i < 16; i++) begin
      sample();
      chk("scan_old_data", bus.out_data, (i / 4) * 16 + i % 4);
      if (i == 10) chk("held_full", bus.shadow_full, 1);
      @(negedge clk);
      idle();
      if (i < 4) begin
        bus.ld_valid = 1;
        bus.ld_row = 2'(i);
        bus.ld_data = 32'hA0A1A2A3 + i * 32'h04040404;
      end
      bus.swap_req = i >= 4;
    end
    sample();
    chk("late_swap_full", bus.shadow_full, 0);
    rd(1, 2);
    sample();
    chk("rd_new_1_2", bus.out_data, 32'hA6);
    // Row 1 twice, row 2 missing: no swap until row 2 arrives
    load(0, 32'h01020304);
    load(1, 32'h11121314);
    load(1, 32'h55667788);
    load(3, 32'h31323334);
    @(negedge clk);
    idle();
    bus.swap_req = 1;
    repeat (3) sample();
    chk("partial_full", bus.shadow_full, 0);
    rd(0, 0);
    sample();
    chk("partial_no_swap", bus.out_data, 32'hA0);
    load(2, 32'h21222324);
    sample();
    chk("complete_full", bus.shadow_full, 1);
    @(negedge clk);
    idle();
    bus.swap_req = 1;
    sample();
    rd(1, 0);
    sample();
    chk("rewrite_1_0", bus.out_data, 32'h55);
    rd(1, 3);
    sample();
    chk("rewrite_1_3", bus.out_data, 32'h88);
    // Asynchronous reset while element 7 of a scan is on the output
    @(negedge clk);
    idle();
    bus.scan_start = 1;
    sample();
    @(negedge clk);
    idle();
    repeat (7) sample();
    chk("elem7", bus.out_data, 32'h88);
    #1 rst_n = 0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_busy", bus.scan_busy, 0);
    chk("arst_act", bus.act_valid, 0);
    chk("arst_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) sample();
    chk("post_rst_quiet", bus.out_valid, 0);
    rd(2, 1);
    sample();
    chk("post_rst_rd", bus.out_data, 0);
    chk("post_rst_rd_valid", bus.out_valid, 1);
    @(negedge clk);
    idle();
    repeat (2) sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
